addr_burst_sequencer: RTL and testbench

//  Drains the host-loaded address FIFO into the vector datapath under program control (run/end/abort/freeze).

---
 rtl/addr_burst_sequencer_if.sv | 23 ++
 rtl/addr_burst_sequencer.sv | 155 +++++++++++++++
 tb/tb_addr_burst_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addr_burst_sequencer_if.sv
// Address sequencer bus: FIFO read side (standard, non-FWFT) plus the
// valid/ready address stream towards the vector generator.
// master = sequencer, slave = FIFO/datapath side.
interface addr_burst_sequencer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic                  addr_valid;
  logic                  addr_ready;

  modport master (
    input  fifo_dout, fifo_empty, addr_ready,
    output fifo_rd_en, addr_out, addr_valid
  );

  modport slave (
    output fifo_dout, fifo_empty, addr_ready,
    input  fifo_rd_en, addr_out, addr_valid
  );
endinterface

// File: rtl/addr_burst_sequencer.sv
// addr_burst_sequencer: drains the host-loaded address FIFO into the vector
// datapath under run/end/abort/freeze control. Each FIFO word becomes one
// address, or 1+consec_count addresses stepping by ADDR_STRIDE.
// Optional feature macro: ADDR_SEQ_STATS_EN (issued/stall statistics counters).
module addr_burst_sequencer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int ADDR_STRIDE = 4,
  parameter int STAT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_program_i,
  input  logic                  end_program_i,
  input  logic                  abort_program_i,
  input  logic                  freeze_addr_fifo_i,
  input  logic                  send_consec_addr_i,
  input  logic [7:0]            consec_count_i,
  addr_burst_sequencer_if.master bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  aborted_o,
  output logic [STAT_WIDTH-1:0] issued_cnt_o,
  output logic [STAT_WIDTH-1:0] stall_cnt_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]            state_q, state_d;
  logic                  run_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic [7:0]            rem_q, rem_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;

  logic run_edge, start, hs;

  assign run_edge = run_program_i & ~run_q;
  assign start    = (state_q == S_IDLE) & run_edge & ~abort_program_i;
  assign hs       = valid_q & bus.addr_ready;

  // The FIFO is non-FWFT: the read strobe must be seen in FETCH so that
  // fifo_dout is valid during LOAD. Hence this strobe is decoded from the
  // registered state rather than delayed by another flop.
  assign bus.fifo_rd_en = reset & (state_q == S_FETCH) & ~bus.fifo_empty &
                          ~freeze_addr_fifo_i;

  assign bus.addr_out   = addr_q;
  assign bus.addr_valid = valid_q;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = done_q;
  assign aborted_o      = aborted_q;

  // Next-state logic; abort outranks every other event outside IDLE.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    if (state_q != S_IDLE && abort_program_i) begin
      // Any word read this cycle is simply never loaded.
      state_d   = S_IDLE;
      valid_d   = 1'b0;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_d = S_FETCH;
        end
        S_FETCH: begin
          // Pending words are always drained before end_program is honoured.
          if (!freeze_addr_fifo_i) begin
            if (!bus.fifo_empty) state_d = S_LOAD;
            else if (end_program_i) state_d = S_FINISH;
          end
        end
        S_LOAD: begin
          addr_d  = bus.fifo_dout;
          rem_d   = send_consec_addr_i ? consec_count_i : 8'd0;
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
        S_ISSUE: begin
          // Freeze only gates FIFO reads; an open burst always completes.
          if (hs) begin
            if (rem_q == 8'd0) begin
              valid_d = 1'b0;
              state_d = S_FETCH;
            end else begin
              addr_d = addr_q + ADDR_WIDTH'(ADDR_STRIDE);
              rem_d  = rem_q - 8'd1;
            end
          end
        end
        S_FINISH: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control/datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      run_q     <= 1'b0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      rem_q     <= 8'd0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_program_i;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      rem_q     <= rem_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

`ifdef ADDR_SEQ_STATS_EN
  logic [STAT_WIDTH-1:0] issued_q, stall_q;

  // Per-program statistics: cleared at program start, saturating, held after.
  always_ff @(posedge clk) begin
    if (!reset) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else if (start) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (hs && !(&issued_q)) issued_q <= issued_q + 1'b1;
      if (valid_q && !bus.addr_ready && !(&stall_q)) stall_q <= stall_q + 1'b1;
    end
  end

  assign issued_cnt_o = issued_q;
  assign stall_cnt_o  = stall_q;
`else
  assign issued_cnt_o = '0;
  assign stall_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_addr_burst_sequencer.sv
// Bench for addr_burst_sequencer: FIFO model, address scoreboard, a table of
// whole-program vectors and hand sequences for timing/abort/freeze/reset.
module tb_addr_burst_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, run, endp, abort, freeze, burst;
  logic [7:0]  cnt;
  logic        busy, done, aborted;
  logic [31:0] issued, stall;

  addr_burst_sequencer_if #(.ADDR_WIDTH(32)) bus();

  addr_burst_sequencer #(.ADDR_WIDTH(32), .ADDR_STRIDE(4), .STAT_WIDTH(32)) dut (
    .clk                (clk),
    .reset              (reset),
    .run_program_i      (run),
    .end_program_i      (endp),
    .abort_program_i    (abort),
    .freeze_addr_fifo_i (freeze),
    .send_consec_addr_i (burst),
    .consec_count_i     (cnt),
    .bus                (bus.master),
    .busy_o             (busy),
    .done_o             (done),
    .aborted_o          (aborted),
    .issued_cnt_o       (issued),
    .stall_cnt_o        (stall)
  );

  int errs = 0, chks = 0;

  // FIFO model: non-FWFT, data appears the cycle after the read strobe.
  logic [31:0] fifo_q[$];
  int pushed_n = 0, popped_n = 0, dropped_n = 0;
  assign bus.fifo_empty = (pushed_n == popped_n + dropped_n);
  always @(posedge clk)
    if (bus.fifo_rd_en && fifo_q.size() > 0) begin
      bus.fifo_dout <= fifo_q.pop_front();
      popped_n      <= popped_n + 1;
    end

  // Ready: 0 = manual, 1 = always ready, 2 = drop for one cycle after each accept.
  int   rmode = 1;
  logic man_rdy = 1'b1, alt_rdy = 1'b1, acc_last = 1'b0;
  assign bus.addr_ready = (rmode == 0) ? man_rdy : (rmode == 1) ? 1'b1 : alt_rdy;
  always @(posedge clk) begin
    #1;
    alt_rdy = !acc_last;
  end

  // Monitor on the falling edge: record accepted addresses and pulses.
  logic [31:0] exp_q[$], acc_q[$];
  int          rd_cnt = 0, done_cnt = 0, abort_cnt = 0, hold_bad = 0;
  logic        hold_chk = 1'b0, abort_prev = 1'b0;
  logic [31:0] hold_addr = '0;
  always @(negedge clk) begin
    if (reset) begin
      if (bus.fifo_rd_en) rd_cnt++;
      if (done) done_cnt++;
      if (aborted) abort_cnt++;
      if (hold_chk && !abort_prev && !(bus.addr_valid && bus.addr_out == hold_addr))
        hold_bad++;
      if (bus.addr_valid && bus.addr_ready) acc_q.push_back(bus.addr_out);
      hold_chk   = bus.addr_valid && !bus.addr_ready;
      hold_addr  = bus.addr_out;
      abort_prev = abort;
      acc_last   = bus.addr_valid && bus.addr_ready;
    end else begin
      hold_chk = 1'b0;
      acc_last = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Push a word into the FIFO and the addresses it should produce into the scoreboard.
  task automatic push_word(input logic [31:0] w);
    int n;
    fifo_q.push_back(w);
    pushed_n++;
    n = burst ? int'(cnt) + 1 : 1;
    for (int i = 0; i < n; i++) exp_q.push_back(w + 32'(4 * i));
  endtask

  task automatic flush();
    dropped_n += fifo_q.size();
    fifo_q.delete();
    exp_q.delete();
    acc_q.delete();
  endtask

  task automatic start();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic wait_end(input string name, input int max);
    int d0, a0;
    d0 = done_cnt;
    a0 = abort_cnt;
    for (int i = 0; i < max; i++) begin
      tick();
      if (done_cnt != d0 || abort_cnt != a0) break;
    end
    chk({name, " end seen"}, 64'(done_cnt != d0 || abort_cnt != a0), 64'd1);
  endtask

  task automatic sb_check(input string name);
    while (acc_q.size() > 0 && exp_q.size() > 0)
      chk({name, " addr"}, acc_q.pop_front(), exp_q.pop_front());
    chk({name, " missing addrs"}, exp_q.size(), 0);
    chk({name, " extra addrs"}, acc_q.size(), 0);
    flush();
  endtask

  function automatic int stat_exp(input int v);
`ifdef ADDR_SEQ_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  typedef struct {
    logic [31:0] base;
    logic [31:0] step;
    int          nw;
    logic        bst;
    logic [7:0]  cnt;
    int          rm;
    int          e_iss;
    int          e_stall;
  } vec_t;

  vec_t tv[7];

  initial begin
    int d0, a0, r0;

    tv[0] = '{32'h0000_1000, 32'h0,   1, 1'b0, 8'd0, 1, 1, 0};
    tv[1] = '{32'h0000_2000, 32'h0,   1, 1'b1, 8'd3, 1, 4, 0};
    tv[2] = '{32'hFFFF_FFF8, 32'h0,   1, 1'b1, 8'd2, 2, 3, 2};
    tv[3] = '{32'h0000_3000, 32'h100, 3, 1'b0, 8'd0, 1, 3, 0};
    tv[4] = '{32'h0000_4000, 32'h10,  2, 1'b1, 8'd0, 2, 2, 0};
    tv[5] = '{32'h0000_5000, 32'h40,  2, 1'b1, 8'd1, 2, 4, 2};
    tv[6] = '{32'h0000_6000, 32'h0,   1, 1'b0, 8'd5, 1, 1, 0};

    reset = 1'b0; run = 1'b0; endp = 1'b0; abort = 1'b0; freeze = 1'b0;
    burst = 1'b0; cnt = 8'd0;
    tick(3);
    chk("reset busy",    busy, 0);
    chk("reset done",    done, 0);
    chk("reset aborted", aborted, 0);
    chk("reset valid",   bus.addr_valid, 0);
    chk("reset addr",    bus.addr_out, 0);
    chk("reset rd_en",   bus.fifo_rd_en, 0);
    chk("reset issued",  issued, 0);
    chk("reset stall",   stall, 0);
    reset = 1'b1;
    tick(2);

    // Whole programs from the table.
    for (int v = 0; v < 7; v++) begin
      burst = tv[v].bst;
      cnt   = tv[v].cnt;
      rmode = tv[v].rm;
      for (int w = 0; w < tv[v].nw; w++) push_word(tv[v].base + tv[v].step * 32'(w));
      d0 = done_cnt; a0 = abort_cnt;
      endp = 1'b1;
      start();
      wait_end($sformatf("vec%0d", v), 200);
      endp = 1'b0;
      tick(2);
      chk($sformatf("vec%0d done pulses", v), done_cnt - d0, 1);
      chk($sformatf("vec%0d abort pulses", v), abort_cnt - a0, 0);
      chk($sformatf("vec%0d busy", v), busy, 0);
      sb_check($sformatf("vec%0d", v));
      chk($sformatf("vec%0d issued_cnt", v), issued, stat_exp(tv[v].e_iss));
      chk($sformatf("vec%0d stall_cnt", v), stall, stat_exp(tv[v].e_stall));
    end

    // Burst timing: 0x2000..0x200C on four consecutive cycles, 2-cycle latency.
    rmode = 0; man_rdy = 1'b1; burst = 1'b1; cnt = 8'd3;
    push_word(32'h2000);
    d0 = done_cnt;
    start();
    chk("tim fetch rd_en", bus.fifo_rd_en, 1);
    chk("tim fetch busy", busy, 1);
    tick();
    chk("tim load valid", bus.addr_valid, 0);
    chk("tim load rd_en", bus.fifo_rd_en, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tim beat%0d valid", i), bus.addr_valid, 1);
      chk($sformatf("tim beat%0d addr", i), bus.addr_out, 32'h2000 + 32'(4 * i));
      tick();
    end
    chk("tim after valid", bus.addr_valid, 0);
    chk("tim after rd_en", bus.fifo_rd_en, 0);
    endp = 1'b1;
    wait_end("tim", 50);
    endp = 1'b0;
    tick();
    chk("tim done pulses", done_cnt - d0, 1);
    sb_check("tim");

    // Abort on the 2nd of 5 addresses; later FIFO words stay unread.
    burst = 1'b1; cnt = 8'd4; man_rdy = 1'b1;
    push_word(32'h7000); push_word(32'h8000); push_word(32'h9000);
    d0 = done_cnt; a0 = abort_cnt; r0 = rd_cnt;
    start();
    tick(2);
    chk("abt first addr", bus.addr_out, 32'h7000);
    tick();
    chk("abt second addr", bus.addr_out, 32'h7004);
    man_rdy = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt valid", bus.addr_valid, 0);
    chk("abt pulse", aborted, 1);
    chk("abt busy", busy, 0);
    tick();
    chk("abt pulse width", aborted, 0);
    chk("abt no done", done_cnt - d0, 0);
    chk("abt pulse count", abort_cnt - a0, 1);
    chk("abt fifo left", fifo_q.size(), 2);
    chk("abt reads", rd_cnt - r0, 1);
    chk("abt accepted n", acc_q.size(), 1);
    if (acc_q.size() > 0) chk("abt accepted addr", acc_q[0], 32'h7000);
    flush();

    // Abort in IDLE beats a run edge.
    run = 1'b1; abort = 1'b1;
    tick(2);
    chk("idle abort busy", busy, 0);
    chk("idle abort pulse", aborted, 0);
    run = 1'b0; abort = 1'b0;
    tick();

    // Freeze with two words waiting.
    rmode = 1; burst = 1'b0; cnt = 8'd0;
    push_word(32'hA000); push_word(32'hA100);
    freeze = 1'b1; r0 = rd_cnt; d0 = done_cnt;
    start();
    tick(10);
    chk("frz reads", rd_cnt - r0, 0);
    chk("frz busy", busy, 1);
    chk("frz fifo", fifo_q.size(), 2);
    freeze = 1'b0; endp = 1'b1;
    wait_end("frz", 100);
    endp = 1'b0;
    tick();
    chk("frz done pulses", done_cnt - d0, 1);
    sb_check("frz");

    // Empty FIFO: wait for the host, then drain and finish.
    d0 = done_cnt;
    start();
    tick(20);
    chk("emp busy", busy, 1);
    chk("emp no done", done_cnt - d0, 0);
    chk("emp valid", bus.addr_valid, 0);
    push_word(32'h40);
    endp = 1'b1;
    wait_end("emp", 50);
    endp = 1'b0;
    tick();
    chk("emp done pulses", done_cnt - d0, 1);
    sb_check("emp");

    // Reset in the middle of a stalled burst.
    rmode = 0; man_rdy = 1'b0; burst = 1'b1; cnt = 8'd4;
    push_word(32'hB000); push_word(32'hC000);
    start();
    tick(3);
    chk("rst held addr", bus.addr_out, 32'hB000);
    chk("rst held valid", bus.addr_valid, 1);
    reset = 1'b0;
    tick();
    chk("rst valid", bus.addr_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst addr", bus.addr_out, 0);
    chk("rst fifo left", fifo_q.size(), 1);
    reset = 1'b1;
    flush();
    tick(2);

    chk("addr held while stalled", hold_bad, 0);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
